// File: rtl/rst_conditioner.sv
// -----------------------------------------------------------------------------
// rst_conditioner
//
// Merges every board reset source into one clean active-low reset, rst_n_o,
// which feeds the clock/reset generator (PLL reset and the wb/sdram reset
// shift registers). The raw push-button is synchronised and debounced. A
// software request coming from another clock domain is synchronised and
// edge-detected. Every reset pulse is stretched to a minimum width. The
// cause of the last reset and a saturating count of non-POR resets are
// kept for software.
//
// Ports
//   sys_clk_pad_i  in   1  board clock, the only clock used here
//   rst_n_pad_i    in   1  power-on/config reset, asynchronous, active-low
//   btn_n_i        in   1  raw reset push-button, active-low, asynchronous, bouncy
//   sw_rst_req_i   in   1  software reset request level; a rising edge triggers
//   rst_n_o        out  1  conditioned reset, active-low, registered
//   rst_cause_o    out  2  last cause: 00 power-on, 01 button, 10 software
//   rst_count_o    out  8  non-POR resets since power-on, saturates at 255
// -----------------------------------------------------------------------------
module rst_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PULSE_CYCLES    = 1024,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       sys_clk_pad_i,
   input  logic       rst_n_pad_i,
   input  logic       btn_n_i,
   input  logic       sw_rst_req_i,
   output logic       rst_n_o,
   output logic [1:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(PULSE_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PULSE_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_BTN = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;

   typedef enum logic [0:0] {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] btn_sync_r;
   logic [SYNC_STAGES-1:0] sw_sync_r;
   logic                   btn_sync_s;
   logic                   sw_sync_s;
   logic                   btn_db_r;
   logic [DB_W-1:0]        db_cnt_r;
   logic                   sw_q_r;
   logic                   sw_edge_s;
   state_t                 state_r;
   logic [HOLD_W-1:0]      hold_cnt_r;

   // Increment a reset counter, stopping at all-ones.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      logic [7:0] res;
      if (val == 8'hFF) begin
         res = val;
      end else begin
         res = val + 8'd1;
      end
      return res;
   endfunction

   assign btn_sync_s = btn_sync_r[SYNC_STAGES-1];
   assign sw_sync_s  = sw_sync_r[SYNC_STAGES-1];
   // Only the first cycle of a high request level counts.
   assign sw_edge_s  = sw_sync_s & ~sw_q_r;

   // Synchronisers for button (idle high) and software request (idle low).
   always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
      if (!rst_n_pad_i) begin
         btn_sync_r <= {SYNC_STAGES{1'b1}};
         sw_sync_r  <= {SYNC_STAGES{1'b0}};
      end else begin
         btn_sync_r <= {btn_sync_r[SYNC_STAGES-2:0], btn_n_i};
         sw_sync_r  <= {sw_sync_r[SYNC_STAGES-2:0], sw_rst_req_i};
      end
   end

   // Debouncer: accept a new button level only after it has differed for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
      if (!rst_n_pad_i) begin
         btn_db_r <= 1'b1;
         db_cnt_r <= '0;
      end else if (btn_sync_s == btn_db_r) begin
         db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
         btn_db_r <= btn_sync_s;
         db_cnt_r <= '0;
      end else begin
         db_cnt_r <= db_cnt_r + DB_W'(1);
      end
   end

   // Delayed copy of the synchronised request for edge detection.
   always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
      if (!rst_n_pad_i) begin
         sw_q_r <= 1'b0;
      end else begin
         sw_q_r <= sw_sync_s;
      end
   end

   // Reset FSM. rst_n_o always carries the value of the state being entered,
   // so it changes on the same edge as the state and the cause/count fields.
   always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
      if (!rst_n_pad_i) begin
         state_r     <= ST_HOLD;
         hold_cnt_r  <= '0;
         rst_n_o     <= 1'b0;
         rst_cause_o <= CAUSE_POR;
         rst_count_o <= 8'd0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               // Minimum width reached; a button still held keeps us here
               // until its debounced release.
               if ((hold_cnt_r == HOLD_LAST) && btn_db_r) begin
                  state_r <= ST_RUN;
                  rst_n_o <= 1'b1;
               end else begin
                  if (hold_cnt_r != HOLD_LAST) begin
                     hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                  end else begin
                     hold_cnt_r <= hold_cnt_r;
                  end
                  rst_n_o <= 1'b0;
               end
            end
            ST_RUN: begin
               // Button has priority over a simultaneous software edge.
               if (!btn_db_r) begin
                  state_r     <= ST_HOLD;
                  hold_cnt_r  <= '0;
                  rst_n_o     <= 1'b0;
                  rst_cause_o <= CAUSE_BTN;
                  rst_count_o <= sat_inc8(rst_count_o);
               end else if (sw_edge_s) begin
                  state_r     <= ST_HOLD;
                  hold_cnt_r  <= '0;
                  rst_n_o     <= 1'b0;
                  rst_cause_o <= CAUSE_SW;
                  rst_count_o <= sat_inc8(rst_count_o);
               end else begin
                  rst_n_o <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_HOLD;
               hold_cnt_r <= '0;
               rst_n_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_conditioner.sv
// -----------------------------------------------------------------------------
// tb_rst_conditioner
//
// Directed scenarios followed by a randomised phase. A behavioural reference
// model keeps the raw input samples of every clock edge since the last
// power-on reset. It derives the synchronised levels by indexing that
// history. It accepts a debounced change when the last DB synchronised
// samples all disagree with the current level. The pulse width is measured
// from the edge at which the hold period started. Outputs are compared on
// every falling clock edge.
// -----------------------------------------------------------------------------
module tb_rst_conditioner;

   localparam int DB = 8;
   localparam int PW = 16;
   localparam int SS = 2;

   logic       clk          = 1'b0;
   logic       rst_n_pad_i  = 1'b0;
   logic       btn_n_i      = 1'b1;
   logic       sw_rst_req_i = 1'b0;
   logic       rst_n_o;
   logic [1:0] rst_cause_o;
   logic [7:0] rst_count_o;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int n;

   always #5 clk = ~clk;

   rst_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .PULSE_CYCLES    (PW),
      .SYNC_STAGES     (SS)
   ) dut (
      .sys_clk_pad_i (clk),
      .rst_n_pad_i   (rst_n_pad_i),
      .btn_n_i       (btn_n_i),
      .sw_rst_req_i  (sw_rst_req_i),
      .rst_n_o       (rst_n_o),
      .rst_cause_o   (rst_cause_o),
      .rst_count_o   (rst_count_o)
   );

   // ---------------- reference model ----------------
   bit   btn_hist[$];
   bit   sw_hist[$];
   int   m_k          = 0;
   bit   m_db         = 1'b1;
   bit   m_run        = 1'b0;
   int   m_hold_start = 0;
   int   m_cause      = 0;
   int   m_count      = 0;

   // Synchronised button level after edge m (m edges since reset release).
   function automatic bit btn_sync_after(input int m);
      if (m < SS) return 1'b1;
      return btn_hist[m-SS];
   endfunction

   function automatic bit sw_sync_after(input int m);
      if (m < SS) return 1'b0;
      return sw_hist[m-SS];
   endfunction

   task automatic model_reset();
      btn_hist.delete();
      sw_hist.delete();
      m_k          = 0;
      m_db         = 1'b1;
      m_run        = 1'b0;
      m_hold_start = 0;
      m_cause      = 0;
      m_count      = 0;
   endtask

   task automatic model_step();
      bit db_pre;
      bit swe;
      bit all_diff;
      m_k++;
      db_pre = m_db;
      swe    = sw_sync_after(m_k-1) & ~sw_sync_after(m_k-2);
      if (!m_run) begin
         if ((m_k - m_hold_start >= PW) && db_pre) m_run = 1'b1;
      end else if (!db_pre) begin
         m_run = 1'b0; m_hold_start = m_k; m_cause = 1;
         m_count = (m_count < 255) ? m_count + 1 : 255;
      end else if (swe) begin
         m_run = 1'b0; m_hold_start = m_k; m_cause = 2;
         m_count = (m_count < 255) ? m_count + 1 : 255;
      end
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
         if (btn_sync_after(m_k-1-j) == db_pre) all_diff = 1'b0;
      end
      if (all_diff) m_db = btn_sync_after(m_k-1);
      btn_hist.push_back(btn_n_i);
      sw_hist.push_back(sw_rst_req_i);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n_pad_i);
      if (!rst_n_pad_i) model_reset();
      else              model_step();
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check_eq("model_rst_n_o", {31'd0, rst_n_o}, {31'd0, m_run});
         check_eq("model_cause", {30'd0, rst_cause_o}, m_cause);
         check_eq("model_count", {24'd0, rst_count_o}, m_count);
      end
   end

   task automatic tick(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   // Count rising edges until rst_n_o reaches lvl (bounded).
   task automatic wait_level(input logic lvl, output int edges);
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while ((rst_n_o !== lvl) && (edges < 300));
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_rst_n"}, {31'd0, rst_n_o}, 32'd0);
      check_eq({tag, "_cause"}, {30'd0, rst_cause_o}, 32'd0);
      check_eq({tag, "_count"}, {24'd0, rst_count_o}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // 1. Power-on reset
      tick(2);
      check_reset_state("por");
      chk_en = 1'b1;
      #2 rst_n_pad_i = 1'b1;
      wait_level(1'b1, n);
      check_eq("por_low_cycles", n, PW);
      check_eq("por_cause", {30'd0, rst_cause_o}, 32'd0);
      check_eq("por_count", {24'd0, rst_count_o}, 32'd0);

      // 2. Bounce, then held low
      tick(5);
      for (int i = 0; i < 14; i++) begin
         btn_n_i = (i % 2 == 1);
         tick(3);
      end
      check_eq("bounce_no_reset", {31'd0, rst_n_o}, 32'd1);
      check_eq("bounce_count", {24'd0, rst_count_o}, 32'd0);
      btn_n_i = 1'b0;
      wait_level(1'b0, n);
      check_eq("btn_fall_latency", n, SS + DB + 1);
      check_eq("btn_cause", {30'd0, rst_cause_o}, 32'd1);
      check_eq("btn_count", {24'd0, rst_count_o}, 32'd1);

      // 3. Long press then release
      tick(100);
      check_eq("btn_held_low", {31'd0, rst_n_o}, 32'd0);
      btn_n_i = 1'b1;
      wait_level(1'b1, n);
      check_eq("btn_release_latency", n, SS + DB + 1);

      // 4. Software request held high
      tick(4);
      sw_rst_req_i = 1'b1;
      wait_level(1'b0, n);
      check_eq("sw_fall_latency", n, SS + 1);
      check_eq("sw_cause", {30'd0, rst_cause_o}, 32'd2);
      check_eq("sw_count", {24'd0, rst_count_o}, 32'd2);
      wait_level(1'b1, n);
      check_eq("sw_low_cycles", n, PW);
      tick(40);
      check_eq("sw_level_once", {24'd0, rst_count_o}, 32'd2);
      sw_rst_req_i = 1'b0;
      tick(3);
      sw_rst_req_i = 1'b1;
      wait_level(1'b0, n);
      tick(2);
      sw_rst_req_i = 1'b0;
      tick(3);
      sw_rst_req_i = 1'b1;   // second rise while in HOLD
      tick(30);
      check_eq("sw_hold_ignored_cnt", {24'd0, rst_count_o}, 32'd3);
      check_eq("sw_hold_ignored_run", {31'd0, rst_n_o}, 32'd1);
      sw_rst_req_i = 1'b0;
      tick(5);

      // 5. Button and software edge on the same cycle
      btn_n_i = 1'b0;
      tick(8);
      sw_rst_req_i = 1'b1;
      tick(5);
      check_eq("simul_rst_n", {31'd0, rst_n_o}, 32'd0);
      check_eq("simul_cause", {30'd0, rst_cause_o}, 32'd1);
      check_eq("simul_count", {24'd0, rst_count_o}, 32'd4);
      sw_rst_req_i = 1'b0;
      btn_n_i = 1'b1;
      wait_level(1'b1, n);
      tick(3);

      // 5b. Saturation of the reset counter
      for (int i = 0; i < 300; i++) begin
         sw_rst_req_i = 1'b1;
         tick($urandom_range(3, 6));
         sw_rst_req_i = 1'b0;
         wait_level(1'b1, n);
         tick($urandom_range(2, 5));
      end
      check_eq("sat_count", {24'd0, rst_count_o}, 32'd255);
      check_eq("sat_cause", {30'd0, rst_cause_o}, 32'd2);

      // 6. Power-on reset mid-HOLD and mid-debounce
      sw_rst_req_i = 1'b1;
      tick(6);
      #2 rst_n_pad_i = 1'b0;
      #1 check_reset_state("abort_hold");
      sw_rst_req_i = 1'b0;
      tick(2);
      #2 rst_n_pad_i = 1'b1;
      wait_level(1'b1, n);
      check_eq("abort_hold_pulse", n, PW);
      tick(3);
      btn_n_i = 1'b0;
      tick(4);
      #2 rst_n_pad_i = 1'b0;
      #1 check_reset_state("abort_db");
      btn_n_i = 1'b1;
      tick(2);
      #2 rst_n_pad_i = 1'b1;
      wait_level(1'b1, n);
      check_eq("abort_db_pulse", n, PW);
      check_eq("abort_db_count", {24'd0, rst_count_o}, 32'd0);

      // Random phase, compared against the model every cycle
      for (int r = 0; r < 80; r++) begin
         case ($urandom_range(0, 4))
            0: begin
               repeat ($urandom_range(3, 12)) begin
                  btn_n_i = ~btn_n_i;
                  tick($urandom_range(1, 9));
               end
               btn_n_i = 1'b1;
               tick($urandom_range(1, 20));
            end
            1: begin
               btn_n_i = 1'b0;
               tick($urandom_range(9, 40));
               btn_n_i = 1'b1;
               tick($urandom_range(5, 40));
            end
            2: begin
               sw_rst_req_i = 1'b1;
               tick($urandom_range(1, 6));
               sw_rst_req_i = 1'b0;
               tick($urandom_range(1, 25));
            end
            3: tick($urandom_range(5, 30));
            default: begin
               #2 rst_n_pad_i = 1'b0;
               tick($urandom_range(1, 3));
               #2 rst_n_pad_i = 1'b1;
               tick($urandom_range(1, 20));
            end
         endcase
      end
      btn_n_i = 1'b1;
      sw_rst_req_i = 1'b0;
      tick(60);
      check_eq("final_run", {31'd0, rst_n_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
